// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, line idle level and baud divisor helper.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_IDLE = 3'd4
  } rx_state_e;

  localparam logic LINE_IDLE = 1'b1;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Flop chain that brings the asynchronous rx line into the clk domain; powers up at line idle.
module uart_rx_sync
  import uart_pkg::*;
#(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= {STAGES{LINE_IDLE}};
    else      sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, DATA_BITS data (LSB first), 1 stop, no parity; mid-bit sampling.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned BAUD_RATE   = 9600,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_err
);

  localparam int unsigned CPB      = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HALF_BIT = CPB / 2;
  localparam int unsigned CNT_W    = $clog2(CPB);
  localparam int unsigned IDX_W    = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  if (CPB < 4) begin : g_bad_baud
    $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("uart_rx: SYNC_STAGES must be 2 or 3");
  end

  logic rxs, rxs_prev_q;

  uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rxs)
  );

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 busy_q;
  logic                 bit_done, half_done;

  assign bit_done  = (cnt_q == BIT_LAST);
  assign half_done = (cnt_q == HALF_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (rxs_prev_q && !rxs) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        // Start bit must still be low at its centre, otherwise treat the edge as a glitch
        if (half_done) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rxs ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (bit_done) begin
          cnt_d                 = '0;
          shift_d               = shift_q >> 1;
          shift_d[DATA_BITS-1]  = rxs;
          idx_d                 = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (bit_done) begin
          cnt_d = '0;
          if (rxs) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = RX_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = RX_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_WAIT_IDLE: begin
        // Hold off re-arming until a break or stuck-low line has released
        if (rxs) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RX_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
      rxs_prev_q <= LINE_IDLE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      busy_q     <= (state_d != RX_IDLE);
      rxs_prev_q <= rxs;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign rx_busy   = busy_q;
  assign frame_err = ferr_q;

endmodule
